// File: rtl/mmu_pkg.sv
// Shared MMU types: page-table-walker arbiter states, PTE permission layout
// and default walk timeout.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ptw_arb_state_e;

  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_perm_t;

  localparam int PTW_ARB_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational mask-based round-robin arbiter: lowest requester at or above
// ptr wins, otherwise the lowest requester overall.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] mask;
  logic [N-1:0] sel;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IDX_W'(i) >= ptr);
    end
  end

  assign sel = (|(req & mask)) ? (req & mask) : req;
  assign gnt = sel & (~sel + N'(1));

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ptw_client_arbiter.sv
// N-client front-end for the shared page-table walker: round-robin request
// arbitration, one walk in flight, response routing, flush drain and timeout.
//
// state | meaning
// IDLE  | arbitrating client requests
// REQ   | presenting latched request to the PTW
// WAIT  | walk in flight, counting towards timeout
// DRAIN | swallowing a PTW response nobody wants any more
module ptw_client_arbiter
  import mmu_pkg::*;
#(
  parameter int N_CLIENTS   = 2,
  parameter int VPN_W       = 27,
  parameter int PPN_W       = 44,
  parameter int LEVEL_W     = 2,
  parameter int TIMEOUT_CYC = PTW_ARB_TIMEOUT_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_CLIENTS-1:0]       cl_req_valid_i,
  input  logic [N_CLIENTS*VPN_W-1:0] cl_req_vpn_i,
  input  logic [N_CLIENTS*2-1:0]     cl_req_prv_i,
  input  logic [N_CLIENTS-1:0]       cl_req_store_i,
  input  logic [N_CLIENTS-1:0]       cl_req_fetch_i,
  output logic [N_CLIENTS-1:0]       cl_req_ready_o,
  output logic [N_CLIENTS-1:0]       cl_resp_valid_o,
  output logic                       cl_resp_error_o,
  output logic [PPN_W-1:0]           cl_resp_ppn_o,
  output logic [7:0]                 cl_resp_perm_o,
  output logic [LEVEL_W-1:0]         cl_resp_level_o,
  output logic [N_CLIENTS-1:0]       cl_invalidate_o,
  output logic                       ptw_req_valid_o,
  output logic [VPN_W-1:0]           ptw_req_vpn_o,
  output logic [1:0]                 ptw_req_prv_o,
  output logic                       ptw_req_store_o,
  output logic                       ptw_req_fetch_o,
  input  logic                       ptw_req_ready_i,
  input  logic                       ptw_resp_valid_i,
  input  logic                       ptw_resp_error_i,
  input  logic [PPN_W-1:0]           ptw_resp_ppn_i,
  input  logic [7:0]                 ptw_resp_perm_i,
  input  logic [LEVEL_W-1:0]         ptw_resp_level_i,
  input  logic                       flush_i,
  output logic [N_CLIENTS-1:0]       pmu_grant_o,
  output logic                       pmu_timeout_o
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  ptw_arb_state_e       state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, owner_q, owner_nxt, win_idx;
  logic [N_CLIENTS-1:0] win_gnt, grant_hs;
  logic                 accept, resp_take, timeout_hit, timeout_take, walk_abort;
  logic                 flush_q;
  pte_perm_t            resp_perm_q;

  rr_arbiter #(.N(N_CLIENTS)) u_rr (
    .req (cl_req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign grant_hs     = cl_req_ready_o & cl_req_valid_i;
  assign accept       = |grant_hs;
  assign resp_take    = (state_q == WAIT) && ptw_resp_valid_i && !flush_i;
  assign timeout_take = (state_q == WAIT) && timeout_hit && !ptw_resp_valid_i && !flush_i;
  assign walk_abort   = flush_i && ((state_q == REQ) || (state_q == WAIT));
  assign owner_nxt    = (owner_q == IDX_W'(N_CLIENTS - 1)) ? '0 : owner_q + IDX_W'(1);

  if (TIMEOUT_CYC > 0) begin : g_timeout
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                 cnt_q <= '0;
      else if (state_q == WAIT)  cnt_q <= cnt_q + CNT_W'(1);
      else                       cnt_q <= '0;
    end

    // cnt_q counts completed WAIT cycles, so the last allowed one sees TIMEOUT_CYC-1
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = REQ;
      REQ: begin
        if (flush_i)              state_d = IDLE;
        else if (ptw_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        // a flush coinciding with the response means nothing is left to drain
        if (flush_i)               state_d = ptw_resp_valid_i ? IDLE : DRAIN;
        else if (ptw_resp_valid_i) state_d = IDLE;
        else if (timeout_hit)      state_d = DRAIN;
      end
      DRAIN: if (ptw_resp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cl_req_ready_o  = '0;
    ptw_req_valid_o = 1'b0;
    case (state_q)
      IDLE:    if (!flush_i && !rst_i) cl_req_ready_o = win_gnt;
      REQ:     ptw_req_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      flush_q         <= 1'b0;
      pmu_grant_o     <= '0;
      pmu_timeout_o   <= 1'b0;
      ptw_req_vpn_o   <= '0;
      ptw_req_prv_o   <= '0;
      ptw_req_store_o <= 1'b0;
      ptw_req_fetch_o <= 1'b0;
      cl_resp_valid_o <= '0;
      cl_resp_error_o <= 1'b0;
      cl_resp_ppn_o   <= '0;
      resp_perm_q     <= '0;
      cl_resp_level_o <= '0;
    end else begin
      flush_q         <= flush_i;
      pmu_grant_o     <= grant_hs;
      pmu_timeout_o   <= 1'b0;
      cl_resp_valid_o <= '0;
      if (accept) begin
        owner_q         <= win_idx;
        ptw_req_vpn_o   <= cl_req_vpn_i[int'(win_idx)*VPN_W +: VPN_W];
        ptw_req_prv_o   <= cl_req_prv_i[int'(win_idx)*2 +: 2];
        ptw_req_store_o <= cl_req_store_i[win_idx];
        ptw_req_fetch_o <= cl_req_fetch_i[win_idx];
      end
      if (resp_take) begin
        cl_resp_valid_o <= N_CLIENTS'(1) << owner_q;
        cl_resp_error_o <= ptw_resp_error_i;
        cl_resp_ppn_o   <= ptw_resp_ppn_i;
        resp_perm_q     <= pte_perm_t'(ptw_resp_perm_i);
        cl_resp_level_o <= ptw_resp_level_i;
      end else if (timeout_take) begin
        cl_resp_valid_o <= N_CLIENTS'(1) << owner_q;
        cl_resp_error_o <= 1'b1;
        cl_resp_ppn_o   <= '0;
        resp_perm_q     <= '0;
        cl_resp_level_o <= '0;
        pmu_timeout_o   <= 1'b1;
      end
      // any walk that ends, however it ends, hands priority to the next client
      if (resp_take || timeout_take || walk_abort) rr_ptr_q <= owner_nxt;
    end
  end

  assign cl_resp_perm_o  = resp_perm_q;
  assign cl_invalidate_o = {N_CLIENTS{flush_q}};

endmodule

// File: tb/tb_ptw_client_arbiter.sv
// Scoreboard bench for ptw_client_arbiter (4 clients, 8-cycle walk timeout).
module tb_ptw_client_arbiter;

  localparam int N  = 4;
  localparam int VW = 27;
  localparam int PW = 44;
  localparam int LW = 2;

  typedef struct packed {
    logic [N-1:0]  who;
    logic          err;
    logic [PW-1:0] ppn;
    logic [7:0]    perm;
    logic [LW-1:0] lvl;
  } resp_t;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    cl_req_valid = '0;
  logic [N*VW-1:0] cl_req_vpn = '0;
  logic [N*2-1:0]  cl_req_prv = '0;
  logic [N-1:0]    cl_req_store = '0;
  logic [N-1:0]    cl_req_fetch = '0;
  logic [N-1:0]    cl_req_ready_o, cl_resp_valid_o, cl_invalidate_o, pmu_grant_o;
  logic            cl_resp_error_o, ptw_req_valid_o, ptw_req_store_o, ptw_req_fetch_o, pmu_timeout_o;
  logic [PW-1:0]   cl_resp_ppn_o;
  logic [7:0]      cl_resp_perm_o;
  logic [LW-1:0]   cl_resp_level_o;
  logic [VW-1:0]   ptw_req_vpn_o;
  logic [1:0]      ptw_req_prv_o;
  logic            ptw_req_ready = 1'b0;
  logic            ptw_resp_valid = 1'b0;
  logic            ptw_resp_error = 1'b0;
  logic [PW-1:0]   ptw_resp_ppn = '0;
  logic [7:0]      ptw_resp_perm = '0;
  logic [LW-1:0]   ptw_resp_level = '0;
  logic            flush = 1'b0;
  logic [103:0]    all_out;

  int n_checks = 0;
  int n_fail   = 0;
  resp_t        exp_resp[$];
  logic [N-1:0] exp_grant[$];

  ptw_client_arbiter #(
    .N_CLIENTS(N), .VPN_W(VW), .PPN_W(PW), .LEVEL_W(LW), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cl_req_valid_i(cl_req_valid), .cl_req_vpn_i(cl_req_vpn), .cl_req_prv_i(cl_req_prv),
    .cl_req_store_i(cl_req_store), .cl_req_fetch_i(cl_req_fetch), .cl_req_ready_o(cl_req_ready_o),
    .cl_resp_valid_o(cl_resp_valid_o), .cl_resp_error_o(cl_resp_error_o), .cl_resp_ppn_o(cl_resp_ppn_o),
    .cl_resp_perm_o(cl_resp_perm_o), .cl_resp_level_o(cl_resp_level_o), .cl_invalidate_o(cl_invalidate_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_prv_o(ptw_req_prv_o),
    .ptw_req_store_o(ptw_req_store_o), .ptw_req_fetch_o(ptw_req_fetch_o), .ptw_req_ready_i(ptw_req_ready),
    .ptw_resp_valid_i(ptw_resp_valid), .ptw_resp_error_i(ptw_resp_error), .ptw_resp_ppn_i(ptw_resp_ppn),
    .ptw_resp_perm_i(ptw_resp_perm), .ptw_resp_level_i(ptw_resp_level), .flush_i(flush),
    .pmu_grant_o(pmu_grant_o), .pmu_timeout_o(pmu_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  assign all_out = {cl_req_ready_o, cl_resp_valid_o, cl_resp_error_o, cl_resp_ppn_o, cl_resp_perm_o,
                    cl_resp_level_o, cl_invalidate_o, ptw_req_valid_o, ptw_req_vpn_o, ptw_req_prv_o,
                    ptw_req_store_o, ptw_req_fetch_o, pmu_grant_o, pmu_timeout_o};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Response and grant monitor: pops the expected entry whenever the DUT pulses.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk_i);
      if (!rst_i && (|cl_resp_valid_o)) begin
        if (exp_resp.size() == 0) check("resp_unexpected", cl_resp_valid_o, '0);
        else begin
          r = exp_resp.pop_front();
          check("resp_bus", {cl_resp_valid_o, cl_resp_error_o, cl_resp_ppn_o, cl_resp_perm_o, cl_resp_level_o}, r);
        end
      end
      if (!rst_i && (|pmu_grant_o)) begin
        if (exp_grant.size() == 0) check("grant_unexpected", pmu_grant_o, '0);
        else check("pmu_grant", pmu_grant_o, exp_grant.pop_front());
      end
    end
  end

  function automatic logic [VW+4:0] req_fields(input int k, input logic [VW-1:0] vpn);
    logic [1:0] p;
    p = 2'(k);
    return {1'b1, vpn, p, p[0], ~p[0]};
  endfunction

  task automatic set_fields(input int k, input logic [VW-1:0] vpn);
    logic [1:0] p;
    p = 2'(k);
    cl_req_vpn[k*VW +: VW] = vpn;
    cl_req_prv[k*2 +: 2]   = p;
    cl_req_store[k]        = p[0];
    cl_req_fetch[k]        = ~p[0];
  endtask

  task automatic issue(input int k, input logic [VW-1:0] vpn);
    bit ok;
    ok = 1'b0;
    exp_grant.push_back(4'b0001 << k);
    set_fields(k, vpn);
    cl_req_valid[k] = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      if (cl_req_ready_o[k]) begin
        tick();
        cl_req_valid[k] = 1'b0;
        ok = 1'b1;
      end
    end
    check("grant_wait", ok, 1);
  endtask

  task automatic accept_req(input int k, input logic [VW-1:0] vpn, input int stall);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      seen = ptw_req_valid_o;
    end
    check("ptw_req_wait", seen, 1);
    check("ptw_req_fields", {ptw_req_valid_o, ptw_req_vpn_o, ptw_req_prv_o, ptw_req_store_o, ptw_req_fetch_o},
          req_fields(k, vpn));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("ptw_req_stall", {ptw_req_valid_o, ptw_req_vpn_o, ptw_req_prv_o, ptw_req_store_o, ptw_req_fetch_o,
                              cl_req_ready_o}, {req_fields(k, vpn), 4'b0000});
    end
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
  endtask

  task automatic respond(input int k, input int dly, input logic [PW-1:0] ppn, input logic [7:0] perm,
                         input logic [LW-1:0] lvl);
    repeat (dly) tick();
    ptw_resp_valid = 1'b1;
    ptw_resp_error = 1'b0;
    ptw_resp_ppn   = ppn;
    ptw_resp_perm  = perm;
    ptw_resp_level = lvl;
    tick();
    ptw_resp_valid = 1'b0;
    check("resp_latency", {cl_resp_valid_o, pmu_timeout_o}, {4'b0001 << k, 1'b0});
  endtask

  task automatic full_walk(input int k, input logic [VW-1:0] vpn, input logic [PW-1:0] ppn,
                           input logic [7:0] perm, input logic [LW-1:0] lvl, input int stall, input int dly);
    resp_t r;
    r.who = 4'b0001 << k; r.err = 1'b0; r.ppn = ppn; r.perm = perm; r.lvl = lvl;
    exp_resp.push_back(r);
    issue(k, vpn);
    accept_req(k, vpn, stall);
    respond(k, dly, ppn, perm, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
    #12;
    check("reset_outputs", all_out, '0);
    tick();
    rst_i = 1'b0;
    tick();

    // stale PTW response while idle must be ignored
    ptw_resp_valid = 1'b1; tick(); ptw_resp_valid = 1'b0; tick();
    check("stale_idle_resp", cl_resp_valid_o, '0);

    // tie c0/c1 from reset: c0, c1, then c0 again
    set_fields(0, 27'h111); set_fields(1, 27'h222);
    cl_req_valid = 4'b0011;
    full_walk(0, 27'h111, 44'h10, 8'hCF, 2'd2, 0, 2);
    full_walk(1, 27'h222, 44'h20, 8'hC3, 2'd0, 0, 1);
    cl_req_valid = 4'b0011;
    full_walk(0, 27'h333, 44'h30, 8'h11, 2'd1, 0, 0);
    full_walk(1, 27'h444, 44'h40, 8'h07, 2'd3, 0, 3);

    // single client on a 4-client arbiter
    full_walk(1, 27'h1234, 44'hABC, 8'hFF, 2'd1, 0, 5);

    // wraparound: rr_ptr=2, c0 and c3 pending -> c3 first
    set_fields(0, 27'h5000); set_fields(3, 27'h5003);
    cl_req_valid = 4'b1001;
    full_walk(3, 27'h5003, 44'h503, 8'h5B, 2'd2, 0, 1);
    full_walk(0, 27'h5000, 44'h500, 8'h01, 2'd0, 0, 1);

    // flush in WAIT, PTW answers 3 cycles later
    issue(2, 27'h7777);
    accept_req(2, 27'h7777, 0);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("invalidate_set", cl_invalidate_o, 4'hF);
    set_fields(1, 27'h6161);
    cl_req_valid[1] = 1'b1;
    tick();
    check("invalidate_pulse", cl_invalidate_o, 4'h0);
    check("drain_no_ready", cl_req_ready_o, 4'h0);
    tick();
    ptw_resp_valid = 1'b1; tick(); ptw_resp_valid = 1'b0;
    check("flush_no_resp", cl_resp_valid_o, '0);
    full_walk(1, 27'h6161, 44'h616, 8'h3C, 2'd1, 0, 0);

    // flush together with the PTW response: straight back to IDLE
    issue(0, 27'h0F0F);
    accept_req(0, 27'h0F0F, 0);
    tick();
    flush = 1'b1; ptw_resp_valid = 1'b1; tick(); flush = 1'b0; ptw_resp_valid = 1'b0;
    check("flush_resp_no_resp", cl_resp_valid_o, '0);
    full_walk(2, 27'h2222, 44'h222, 8'h81, 2'd2, 0, 1);

    // timeout after 8 WAIT cycles, late response swallowed
    r.who = 4'b1000; r.err = 1'b1; r.ppn = '0; r.perm = '0; r.lvl = '0;
    issue(3, 27'h3333);
    accept_req(3, 27'h3333, 0);
    exp_resp.push_back(r);
    repeat (7) tick();
    check("no_early_timeout", {cl_resp_valid_o, pmu_timeout_o}, '0);
    tick();
    check("timeout_resp", {cl_resp_valid_o, pmu_timeout_o, cl_resp_error_o}, {4'b1000, 1'b1, 1'b1});
    tick(); tick();
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 44'hDEAD; tick(); ptw_resp_valid = 1'b0;
    check("late_resp_swallowed", cl_resp_valid_o, '0);
    full_walk(0, 27'h0A0A, 44'hA0A, 8'h55, 2'd0, 0, 2);

    // response on the 8th WAIT cycle beats the timeout
    full_walk(1, 27'h0B0B, 44'hB0B, 8'hAA, 2'd3, 0, 7);

    // PTW stalls 10 cycles with another client waiting
    set_fields(0, 27'h0C0C);
    cl_req_valid[0] = 1'b1;
    full_walk(2, 27'h0D0D, 44'hD0D, 8'h66, 2'd1, 10, 1);
    full_walk(0, 27'h0C0C, 44'hC0C, 8'h99, 2'd2, 0, 0);

    // reset during WAIT; rr_ptr was 1 so c0 winning the tie shows it cleared
    issue(2, 27'h0E0E);
    accept_req(2, 27'h0E0E, 0);
    tick();
    rst_i = 1'b1;
    #1;
    check("reset_async", all_out, '0);
    tick();
    rst_i = 1'b0;
    ptw_resp_valid = 1'b1; tick(); ptw_resp_valid = 1'b0;
    check("stale_after_reset", cl_resp_valid_o, '0);
    set_fields(0, 27'h1010); set_fields(1, 27'h1111);
    cl_req_valid = 4'b0011;
    full_walk(0, 27'h1010, 44'h1010, 8'h12, 2'd0, 0, 1);
    full_walk(1, 27'h1111, 44'h1111, 8'h34, 2'd1, 0, 1);

    repeat (5) tick();
    check("resp_queue_empty", exp_resp.size(), 0);
    check("grant_queue_empty", exp_grant.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
